// File: rtl/ula_seq_multibyte.sv
// Multi-byte ALU sequencer: drives an external 8-bit ALU one byte per clock, LSB first, chaining carry.
// Latency: done pulses NBYTES+1 cycles after start is accepted; one operation per NBYTES+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module ula_seq_multibyte #(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES,
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [3:0]   sel_s,
  input  logic         sel_m,
  input  logic         cin,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic [3:0]   alu_s,
  output logic         alu_m,
  output logic         alu_cin,
  input  logic [7:0]   alu_f,
  input  logic         alu_c_out,
  input  logic         alu_a_eq_b,
  input  logic         alu_overflow,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow,
  output logic         eq,
  output logic         zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [NBYTES-1:0][7:0] a_reg;
  logic [NBYTES-1:0][7:0] b_reg;
  logic [NBYTES-1:0][7:0] res_reg;
  logic [3:0]             s_reg;
  logic                   m_reg;
  logic                   carry_reg;
  logic                   eq_acc;
  logic                   last_byte;

  assign last_byte = (idx == IW'(NBYTES - 1));

  // Only the operand bytes and carry are gated; the selects stay on the bus so the ALU sees a stable mode.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    if (state == S_RUN) begin
      alu_a   = a_reg[idx];
      alu_b   = b_reg[idx];
      alu_cin = carry_reg;
    end
  end

  assign alu_s  = s_reg;
  assign alu_m  = m_reg;
  assign result = res_reg;
  assign zero   = (res_reg == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      s_reg     <= '0;
      m_reg     <= 1'b0;
      carry_reg <= 1'b0;
      eq_acc    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      eq        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            s_reg     <= sel_s;
            m_reg     <= sel_m;
            carry_reg <= cin;
            eq_acc    <= 1'b1;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          res_reg[idx] <= alu_f;
          carry_reg    <= alu_c_out;
          eq_acc       <= eq_acc & alu_a_eq_b;
          if (last_byte) begin
            // Flags come from the MSB byte, except eq which folds in every byte.
            overflow  <= alu_overflow;
            carry_out <= alu_c_out;
            eq        <= eq_acc & alu_a_eq_b;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq_multibyte.sv
// Bench for ula_seq_multibyte: a 4-byte and a 1-byte instance, each wrapped around a behavioural 8-bit ALU.
// Results are checked against full-width arithmetic computed directly from the operands.
module tb_ula_seq_multibyte;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic [3:0]   sel_s;
  logic         sel_m, cin;
  logic [7:0]   alu_a, alu_b, alu_f;
  logic [3:0]   alu_s;
  logic         alu_m, alu_cin, alu_c_out, alu_a_eq_b, alu_overflow;
  logic         busy, done, carry_out, overflow, eq, zero;
  logic [W-1:0] result;

  logic         start1;
  logic [7:0]   op_a1, op_b1;
  logic [7:0]   alu_a1, alu_b1, alu_f1;
  logic [3:0]   alu_s1;
  logic         alu_m1, alu_cin1, alu_c_out1, alu_a_eq_b1, alu_overflow1;
  logic         busy1, done1, carry_out1, overflow1, eq1, zero1;
  logic [7:0]   result1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // ALU stand-in: s=0101 in arithmetic mode is A+B+Cin, logic mode is XOR.
  function automatic logic [10:0] alu8(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] s, input logic m, input logic c);
    logic [8:0] sum;
    logic       ov;
    sum = 9'h0;
    ov  = 1'b0;
    if (m) begin
      sum = {1'b0, a ^ b};
    end else if (s == 4'b0101) begin
      sum = {1'b0, a} + {1'b0, b} + {8'h0, c};
      ov  = (a[7] == b[7]) && (sum[7] != a[7]);
    end else begin
      sum = {1'b0, a & b};
    end
    return {ov, (a == b), sum[8], sum[7:0]};
  endfunction

  always_comb {alu_overflow, alu_a_eq_b, alu_c_out, alu_f} = alu8(alu_a, alu_b, alu_s, alu_m, alu_cin);
  always_comb {alu_overflow1, alu_a_eq_b1, alu_c_out1, alu_f1} = alu8(alu_a1, alu_b1, alu_s1, alu_m1, alu_cin1);

  ula_seq_multibyte #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .sel_s(sel_s), .sel_m(sel_m), .cin(cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_c_out(alu_c_out), .alu_a_eq_b(alu_a_eq_b), .alu_overflow(alu_overflow),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .overflow(overflow), .eq(eq), .zero(zero)
  );

  ula_seq_multibyte #(.NBYTES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_a(op_a1), .op_b(op_b1),
    .sel_s(4'b0101), .sel_m(1'b0), .cin(1'b0),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_s(alu_s1), .alu_m(alu_m1), .alu_cin(alu_cin1),
    .alu_f(alu_f1), .alu_c_out(alu_c_out1), .alu_a_eq_b(alu_a_eq_b1), .alu_overflow(alu_overflow1),
    .busy(busy1), .done(done1), .result(result1), .carry_out(carry_out1),
    .overflow(overflow1), .eq(eq1), .zero(zero1)
  );

  // Presents one start pulse; returns at the falling edge right after acceptance.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                          input logic m, input logic c);
    @(negedge clk);
    op_a = a; op_b = b; sel_s = s; sel_m = m; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycles from the start cycle to the done cycle; -1 if done never shows up.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) n = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    op_a = '0; op_b = '0; sel_s = 4'b0101; sel_m = 1'b0; cin = 1'b0; op_a1 = '0; op_b1 = '0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    vectors++; if (result !== '0) begin miscompares++; $display("FAIL reset_result got=%h exp=0", result); end
    vectors++; if ({carry_out, overflow, eq} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got=%b exp=000", {carry_out, overflow, eq}); end
    vectors++; if (zero !== 1'b1) begin miscompares++; $display("FAIL reset_zero got=%b exp=1", zero); end
    vectors++; if ({alu_a, alu_b, alu_cin} !== 17'h0) begin miscompares++; $display("FAIL reset_alu_bus got=%h exp=0", {alu_a, alu_b, alu_cin}); end
    rst = 1'b0;
  endtask

  task automatic test_carry_ripple;
    int n;
    start_op(32'h0000FFFF, 32'h00000001, 4'b0101, 1'b0, 1'b0);
    wait_done(n);
    vectors++; if (n !== 5) begin miscompares++; $display("FAIL ripple_latency got=%0d exp=5", n); end
    vectors++; if (result !== 32'h00010000) begin miscompares++; $display("FAIL ripple_result got=%h exp=00010000", result); end
    vectors++; if ({carry_out, overflow, zero} !== 3'b000) begin miscompares++; $display("FAIL ripple_flags got=%b exp=000", {carry_out, overflow, zero}); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ripple_busy_in_done got=%b exp=1", busy); end
    @(negedge clk);
    vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL ripple_idle got=%b exp=00", {busy, done}); end
  endtask

  task automatic test_overflow;
    int n;
    start_op(32'h7FFFFFFF, 32'h00000001, 4'b0101, 1'b0, 1'b0);
    wait_done(n);
    vectors++; if ({result, overflow, carry_out} !== {32'h80000000, 2'b10}) begin miscompares++; $display("FAIL ovf_pos got=%h/%b%b exp=80000000/10", result, overflow, carry_out); end
    start_op(32'hFFFFFFFF, 32'h00000001, 4'b0101, 1'b0, 1'b0);
    wait_done(n);
    vectors++; if ({result, carry_out, overflow, zero} !== {32'h0, 3'b101}) begin miscompares++; $display("FAIL wrap got=%h/%b%b%b exp=00000000/101", result, carry_out, overflow, zero); end
  endtask

  task automatic test_equality;
    int n;
    logic [W-1:0] av [3] = '{32'h12345678, 32'h92345678, 32'h12345679};
    logic         ev [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      start_op(av[i], 32'h12345678, 4'b0101, 1'b0, 1'b0);
      wait_done(n);
      vectors++; if (eq !== ev[i]) begin miscompares++; $display("FAIL eq_case%0d got=%b exp=%b", i, eq, ev[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int n, dones, guard;
    logic [W-1:0] first_res;
    start_op(32'h01020304, 32'h10203040, 4'b0101, 1'b0, 1'b0);
    dones = 0; guard = 0; first_res = '0;
    while (busy && guard < 20) begin
      vectors++; if ({alu_s, alu_m} !== 5'b01010) begin miscompares++; $display("FAIL hs_select got=%b exp=01010", {alu_s, alu_m}); end
      if (done) begin dones++; first_res = result; end
      start = 1'b1; op_a = $urandom; sel_s = 4'($urandom); sel_m = 1'($urandom);
      @(negedge clk);
      guard++;
    end
    vectors++; if (dones !== 1) begin miscompares++; $display("FAIL hs_done_count got=%0d exp=1", dones); end
    vectors++; if (first_res !== 32'h11223344) begin miscompares++; $display("FAIL hs_result got=%h exp=11223344", first_res); end
    // start is still high in this first IDLE cycle, with a fresh operation presented.
    op_a = 32'h000000FF; op_b = 32'h00000001; sel_s = 4'b0101; sel_m = 1'b0; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL hs_reaccept got=%b exp=1", busy); end
    wait_done(n);
    vectors++; if (result !== 32'h00000100) begin miscompares++; $display("FAIL hs_second_result got=%h exp=00000100", result); end
  endtask

  task automatic test_reset_mid;
    int n, stray;
    start_op(32'hAAAAAAAA, 32'h11111111, 4'b0101, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if ({busy, done, zero} !== 3'b001) begin miscompares++; $display("FAIL rstmid_ctrl got=%b exp=001", {busy, done, zero}); end
    vectors++; if (result !== '0) begin miscompares++; $display("FAIL rstmid_result got=%h exp=0", result); end
    stray = 0;
    repeat (6) begin @(negedge clk); if (done) stray++; end
    vectors++; if (stray !== 0) begin miscompares++; $display("FAIL rstmid_stray_done got=%0d exp=0", stray); end
    start_op(32'h0000FFFF, 32'h00000001, 4'b0101, 1'b0, 1'b1);
    wait_done(n);
    vectors++; if ({n, result} !== {32'd5, 32'h00010001}) begin miscompares++; $display("FAIL rstmid_recover got=%0d/%h exp=5/00010001", n, result); end
  endtask

  task automatic test_random;
    int n;
    logic [W-1:0] a, b, exp_res;
    logic         m, c, exp_co, exp_ov;
    logic [W:0]   sum;
    for (int t = 0; t < 40; t++) begin
      a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      if (t % 5 == 1) begin a[W-1:16] = '1; b = 32'h1; end
      m = ($urandom_range(0, 3) == 0); c = 1'($urandom);
      if (m) begin
        exp_res = a ^ b; exp_co = 1'b0; exp_ov = 1'b0;
      end else begin
        sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        exp_res = sum[W-1:0]; exp_co = sum[W];
        exp_ov = (a[W-1] == b[W-1]) && (exp_res[W-1] != a[W-1]);
      end
      start_op(a, b, 4'b0101, m, c);
      op_a = $urandom; op_b = $urandom; cin = 1'($urandom); sel_m = 1'($urandom);
      wait_done(n);
      vectors++; if (n !== 5) begin miscompares++; $display("FAIL rnd%0d_latency got=%0d exp=5", t, n); end
      vectors++; if (result !== exp_res) begin miscompares++; $display("FAIL rnd%0d_result a=%h b=%h m=%b c=%b got=%h exp=%h", t, a, b, m, c, result, exp_res); end
      vectors++; if ({carry_out, overflow, eq, zero} !== {exp_co, exp_ov, (a == b), (exp_res == '0)}) begin
        miscompares++; $display("FAIL rnd%0d_flags got=%b exp=%b", t, {carry_out, overflow, eq, zero}, {exp_co, exp_ov, (a == b), (exp_res == '0)});
      end
    end
  endtask

  task automatic test_single_byte;
    int n;
    @(negedge clk);
    op_a1 = 8'h7F; op_b1 = 8'h01; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; op_a1 = 8'h00;
    n = 1;
    while (!done1 && n < 20) begin @(negedge clk); n++; end
    vectors++; if (n !== 2) begin miscompares++; $display("FAIL nb1_latency got=%0d exp=2", n); end
    vectors++; if ({result1, overflow1, carry_out1} !== {8'h80, 2'b10}) begin miscompares++; $display("FAIL nb1_result got=%h/%b%b exp=80/10", result1, overflow1, carry_out1); end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_overflow();
    test_equality();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_single_byte();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
